// File: rtl/branch_resolver.sv
// EX-stage conditional branch resolver: decides taken/not-taken from comparator flags,
// issues a valid/ready redirect and holds flush. Optional counters under BR_STATS_EN.
module branch_resolver #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [2:0]       br_funct3,
    input  logic [XLEN-1:0]  br_pc,
    input  logic [XLEN-1:0]  br_imm,
    output logic             BrUn,
    input  logic             BrEq,
    input  logic             BrLT,
    output logic             redirect_valid,
    input  logic             redirect_ready,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush,
    output logic             br_illegal,
    output logic             br_misalign,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

    state_t            state_q, state_d;
    logic              br_ready_q, br_ready_d;
    logic              redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
    logic              flush_q, flush_d;
    logic [3:0]        flush_cnt_q, flush_cnt_d;
    logic              illegal_q, illegal_d;
    logic              misalign_q, misalign_d;
    logic              brun_q, brun_d;
    logic              accept_s;
    logic              taken_s;
    logic              illegal_s;
    logic [XLEN-1:0]   target_s;

    assign target_s  = br_pc + br_imm;
    assign accept_s  = (state_q == IDLE) && br_valid && br_ready_q;
    // The comparator must see the new mode in the same cycle it evaluates rs1/rs2.
    assign BrUn      = (state_q == IDLE) ? br_funct3[1] : brun_q;

    // Branch condition decode from comparator flags.
    always_comb begin
        taken_s   = 1'b0;
        illegal_s = 1'b0;
        case (br_funct3)
            3'b000:  taken_s = BrEq;
            3'b001:  taken_s = !BrEq;
            3'b100:  taken_s = BrLT;
            3'b110:  taken_s = BrLT;
            3'b101:  taken_s = !BrLT;
            3'b111:  taken_s = !BrLT;
            default: illegal_s = 1'b1;
        endcase
    end

    // Next-state and output decode for the resolver FSM.
    always_comb begin
        state_d          = state_q;
        br_ready_d       = br_ready_q;
        redirect_valid_d = redirect_valid_q;
        redirect_pc_d    = redirect_pc_q;
        flush_d          = flush_q;
        flush_cnt_d      = flush_cnt_q;
        illegal_d        = 1'b0;
        misalign_d       = 1'b0;
        brun_d           = brun_q;
        case (state_q)
            IDLE: begin
                br_ready_d = 1'b1;
                if (accept_s) begin
                    brun_d    = br_funct3[1];
                    illegal_d = illegal_s;
                    if (taken_s && target_s[1]) begin
                        misalign_d = 1'b1;
                    end else if (taken_s) begin
                        redirect_pc_d    = target_s;
                        redirect_valid_d = 1'b1;
                        br_ready_d       = 1'b0;
                        state_d          = REDIRECT;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            REDIRECT: begin
                if (redirect_ready) begin
                    redirect_valid_d = 1'b0;
                    flush_d          = 1'b1;
                    flush_cnt_d      = FLUSH_LAST;
                    state_d          = FLUSH;
                end else begin
                    redirect_valid_d = 1'b1;
                end
            end
            FLUSH: begin
                if (flush_cnt_q == 4'd0) begin
                    flush_d    = 1'b0;
                    br_ready_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d          = IDLE;
                br_ready_d       = 1'b0;
                redirect_valid_d = 1'b0;
                flush_d          = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= IDLE;
            br_ready_q       <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= {XLEN{1'b0}};
            flush_q          <= 1'b0;
            flush_cnt_q      <= 4'd0;
            illegal_q        <= 1'b0;
            misalign_q       <= 1'b0;
            brun_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            br_ready_q       <= br_ready_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            flush_q          <= flush_d;
            flush_cnt_q      <= flush_cnt_d;
            illegal_q        <= illegal_d;
            misalign_q       <= misalign_d;
            brun_q           <= brun_d;
        end
    end

    assign br_ready       = br_ready_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush          = flush_q;
    assign br_illegal     = illegal_q;
    assign br_misalign    = misalign_q;

`ifdef BR_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

    // Saturating statistics; misaligned branches still count as taken.
    always_comb begin
        br_cnt_d    = br_cnt_q;
        taken_cnt_d = taken_cnt_q;
        if (accept_s && (br_cnt_q != CNT_MAX)) begin
            br_cnt_d = br_cnt_q + CNT_ONE;
        end else begin
            br_cnt_d = br_cnt_q;
        end
        if (accept_s && taken_s && (taken_cnt_q != CNT_MAX)) begin
            taken_cnt_d = taken_cnt_q + CNT_ONE;
        end else begin
            taken_cnt_d = taken_cnt_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            br_cnt_q    <= {CNT_W{1'b0}};
            taken_cnt_q <= {CNT_W{1'b0}};
        end else begin
            br_cnt_q    <= br_cnt_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign br_cnt    = br_cnt_q;
    assign taken_cnt = taken_cnt_q;
`else
    assign br_cnt    = {CNT_W{1'b0}};
    assign taken_cnt = {CNT_W{1'b0}};
`endif

endmodule
